// File: rtl/clock_pkg.sv
// clock_pkg: shared types, digit limits and time validation
// for the time-of-day counter.
package clock_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      SETTING = 2'd1,
      LOAD    = 2'd2
   } state_t;

   localparam logic [3:0] SEC1_MAX        = 4'd5;
   localparam logic [3:0] DIG_MAX         = 4'd9;
   localparam logic [1:0] HOUR1_MAX       = 2'd2;
   localparam logic [3:0] HOUR2_MAX_AT_20 = 4'd3;

   typedef struct packed {
      logic [1:0] hour1;
      logic [3:0] hour2;
      logic [3:0] min1;
      logic [3:0] min2;
      logic [3:0] sec1;
      logic [3:0] sec2;
   } bcd_time_t;

   // Accepts only times 00:00:00 .. 23:59:59 in BCD.
   function automatic logic is_valid_time(input bcd_time_t t);
      logic v;
      v = 1'b1;
      if (t.hour1 > HOUR1_MAX) v = 1'b0;
      if (t.hour2 > DIG_MAX) v = 1'b0;
      if ((t.hour1 == HOUR1_MAX) &&
          (t.hour2 > HOUR2_MAX_AT_20)) v = 1'b0;
      if (t.min1 > SEC1_MAX) v = 1'b0;
      if (t.min2 > DIG_MAX) v = 1'b0;
      if (t.sec1 > SEC1_MAX) v = 1'b0;
      if (t.sec2 > DIG_MAX) v = 1'b0;
      return v;
   endfunction

endpackage

// File: rtl/clock_counter_tick_gen.sv
// tick_gen: 1 Hz prescaler, one-cycle strobe at terminal count.
// clear holds the count at zero and suppresses the strobe.
module tick_gen
   import clock_pkg::*;
#(
   parameter int TICKS_PER_SEC = 100000000,
   parameter int PRESC_W       = 27
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam logic [PRESC_W-1:0] LP_TERM =
      PRESC_W'(TICKS_PER_SEC - 1);

   logic [PRESC_W-1:0] r_cnt;
   logic               w_term;

   assign w_term = (r_cnt == LP_TERM);
   assign tick   = w_term & ~clear;

   // Free-running 0..TICKS_PER_SEC-1 count, parked at 0 on clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (clear || w_term) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + PRESC_W'(1);
      end
   end

endmodule

// File: rtl/clock_counter.sv
// clock_counter: 24-hour BCD time-of-day counter with set/load
// handshake from the set FSM and a validated load path.
module clock_counter
   import clock_pkg::*;
#(
   parameter int TICKS_PER_SEC = 100000000,
   parameter int PRESC_W       = 27
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       isset,
   input  logic [1:0] set_hour1,
   input  logic [3:0] set_hour2,
   input  logic [3:0] set_min1,
   input  logic [3:0] set_min2,
   input  logic [3:0] set_sec1,
   input  logic [3:0] set_sec2,
   output logic [1:0] hour1,
   output logic [3:0] hour2,
   output logic [3:0] min1,
   output logic [3:0] min2,
   output logic [3:0] sec1,
   output logic [3:0] sec2,
   output logic       sec_pulse,
   output logic       load_err
);

   state_t    r_state;
   state_t    w_next;
   bcd_time_t r_time;
   bcd_time_t w_inc_time;
   bcd_time_t w_set;
   logic      r_sec_pulse;
   logic      r_load_err;
   logic      w_clear;
   logic      w_tick;
   logic      w_inc;
   logic      w_load;
   logic      w_valid;
   logic      w_c1;
   logic      w_c2;
   logic      w_c3;
   logic      w_c4;

   assign w_set   = {set_hour1, set_hour2, set_min1,
                     set_min2, set_sec1, set_sec2};
   assign w_valid = is_valid_time(w_set);

   tick_gen #(
      .TICKS_PER_SEC(TICKS_PER_SEC),
      .PRESC_W      (PRESC_W)
   ) u_tick (
      .clk  (clk),
      .reset(reset),
      .clear(w_clear),
      .tick (w_tick)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= RUN;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state: isset enters/holds setting, release loads once.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         RUN: begin
            if (isset) w_next = SETTING;
         end
         SETTING: begin
            if (!isset) w_next = LOAD;
         end
         LOAD: begin
            w_next = isset ? SETTING : RUN;
         end
         default: begin
            w_next = RUN;
         end
      endcase
   end

   // FSM outputs; isset in RUN clears the prescaler so a
   // coincident terminal tick is dropped.
   always_comb begin
      w_clear = 1'b1;
      w_inc   = 1'b0;
      w_load  = 1'b0;
      unique case (r_state)
         RUN: begin
            w_clear = isset;
            w_inc   = w_tick;
         end
         SETTING: begin
            w_clear = 1'b1;
         end
         LOAD: begin
            w_clear = 1'b1;
            w_load  = 1'b1;
         end
         default: begin
            w_clear = 1'b1;
         end
      endcase
   end

   // BCD ripple: current time plus one second, midnight wrap.
   always_comb begin
      w_inc_time = r_time;
      w_c1 = 1'b0;
      w_c2 = 1'b0;
      w_c3 = 1'b0;
      w_c4 = 1'b0;
      if (r_time.sec2 >= DIG_MAX) begin
         w_inc_time.sec2 = '0;
         w_c1 = 1'b1;
      end else begin
         w_inc_time.sec2 = r_time.sec2 + 4'd1;
      end
      if (w_c1) begin
         if (r_time.sec1 >= SEC1_MAX) begin
            w_inc_time.sec1 = '0;
            w_c2 = 1'b1;
         end else begin
            w_inc_time.sec1 = r_time.sec1 + 4'd1;
         end
      end
      if (w_c2) begin
         if (r_time.min2 >= DIG_MAX) begin
            w_inc_time.min2 = '0;
            w_c3 = 1'b1;
         end else begin
            w_inc_time.min2 = r_time.min2 + 4'd1;
         end
      end
      if (w_c3) begin
         if (r_time.min1 >= SEC1_MAX) begin
            w_inc_time.min1 = '0;
            w_c4 = 1'b1;
         end else begin
            w_inc_time.min1 = r_time.min1 + 4'd1;
         end
      end
      if (w_c4) begin
         if ((r_time.hour1 >= HOUR1_MAX) &&
             (r_time.hour2 >= HOUR2_MAX_AT_20)) begin
            w_inc_time.hour1 = '0;
            w_inc_time.hour2 = '0;
         end else if (r_time.hour2 >= DIG_MAX) begin
            w_inc_time.hour2 = '0;
            w_inc_time.hour1 = r_time.hour1 + 2'd1;
         end else begin
            w_inc_time.hour2 = r_time.hour2 + 4'd1;
         end
      end
   end

   // Time register: validated load, else one-second increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_time <= '0;
      end else if (w_load) begin
         r_time <= w_valid ? w_set : '0;
      end else if (w_inc) begin
         r_time <= w_inc_time;
      end
   end

   // One-cycle status strobes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sec_pulse <= 1'b0;
         r_load_err  <= 1'b0;
      end else begin
         r_sec_pulse <= w_inc;
         r_load_err  <= w_load & ~w_valid;
      end
   end

   assign hour1     = r_time.hour1;
   assign hour2     = r_time.hour2;
   assign min1      = r_time.min1;
   assign min2      = r_time.min2;
   assign sec1      = r_time.sec1;
   assign sec2      = r_time.sec2;
   assign sec_pulse = r_sec_pulse;
   assign load_err  = r_load_err;

endmodule

// File: tb/tb_clock_counter.sv
// tb_clock_counter: table-driven loads, hand sequences and random
// stimulus checked against a seconds-of-day reference model.
module tb_clock_counter;

   localparam int T  = 4;
   localparam int PW = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       isset = 1'b0;
   logic [1:0] set_hour1 = '0;
   logic [3:0] set_hour2 = '0;
   logic [3:0] set_min1 = '0;
   logic [3:0] set_min2 = '0;
   logic [3:0] set_sec1 = '0;
   logic [3:0] set_sec2 = '0;
   logic [1:0] hour1;
   logic [3:0] hour2, min1, min2, sec1, sec2;
   logic       sec_pulse, load_err;

   int total = 0;
   int bad   = 0;

   clock_counter #(
      .TICKS_PER_SEC(T),
      .PRESC_W      (PW)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .isset    (isset),
      .set_hour1(set_hour1),
      .set_hour2(set_hour2),
      .set_min1 (set_min1),
      .set_min2 (set_min2),
      .set_sec1 (set_sec1),
      .set_sec2 (set_sec2),
      .hour1    (hour1),
      .hour2    (hour2),
      .min1     (min1),
      .min2     (min2),
      .sec1     (sec1),
      .sec2     (sec2),
      .sec_pulse(sec_pulse),
      .load_err (load_err)
   );

   always #5 clk = ~clk;

   // Reference model: time as seconds since midnight.
   int m_tod, m_cnt;
   bit m_hold, m_load, m_pulse, m_err;

   function automatic bit ref_valid(output int tod);
      int h1, h2, mi1, mi2, s1, s2, h;
      h1 = set_hour1; h2 = set_hour2;
      mi1 = set_min1; mi2 = set_min2;
      s1 = set_sec1; s2 = set_sec2;
      h = h1 * 10 + h2;
      tod = h * 3600 + (mi1 * 10 + mi2) * 60 + s1 * 10 + s2;
      return (h2 <= 9) && (h < 24) && (mi1 <= 5) &&
             (mi2 <= 9) && (s1 <= 5) && (s2 <= 9);
   endfunction

   always @(posedge clk or posedge reset) begin
      int t;
      if (reset) begin
         m_tod = 0; m_cnt = 0; m_hold = 0;
         m_load = 0; m_pulse = 0; m_err = 0;
      end else begin
         m_pulse = 0;
         m_err = 0;
         if (m_load) begin
            if (ref_valid(t)) m_tod = t;
            else begin m_tod = 0; m_err = 1; end
            m_cnt = 0;
            m_load = 0;
            m_hold = isset;
         end else if (m_hold) begin
            m_cnt = 0;
            if (!isset) begin m_hold = 0; m_load = 1; end
         end else if (isset) begin
            m_hold = 1;
            m_cnt = 0;
         end else if (m_cnt == T - 1) begin
            m_cnt = 0;
            m_pulse = 1;
            m_tod = (m_tod + 1) % 86400;
         end else begin
            m_cnt++;
         end
      end
   end

   function automatic logic [23:0] tod_bcd(int tod);
      int h, mi, s;
      h = tod / 3600; mi = (tod / 60) % 60; s = tod % 60;
      return 24'((h / 10) << 20 | (h % 10) << 16 |
                 (mi / 10) << 12 | (mi % 10) << 8 |
                 (s / 10) << 4 | (s % 10));
   endfunction

   function automatic logic [23:0] dut_bcd();
      return {2'b00, hour1, hour2, min1, min2, sec1, sec2};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic model_chk();
      chk("model_time", 32'(dut_bcd()), 32'(tod_bcd(m_tod)));
      chk("model_pulse", 32'(sec_pulse), 32'(m_pulse));
      chk("model_err", 32'(load_err), 32'(m_err));
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         model_chk();
      end
   endtask

   task automatic drive_set(input logic [23:0] v);
      set_hour1 = v[21:20]; set_hour2 = v[19:16];
      set_min1 = v[15:12]; set_min2 = v[11:8];
      set_sec1 = v[7:4]; set_sec2 = v[3:0];
   endtask

   task automatic load_time(input logic [23:0] v);
      isset = 1'b1;
      drive_set(v);
      step(2);
      isset = 1'b0;
      step(2);
   endtask

   typedef struct {
      logic [23:0] in;
      logic        err;
      logic [23:0] exp;
   } vec_t;

   vec_t tbl[10];

   initial begin
      logic [23:0] held;
      tbl[0] = '{24'h235958, 1'b0, 24'h235958};
      tbl[1] = '{24'h095959, 1'b0, 24'h095959};
      tbl[2] = '{24'h240000, 1'b1, 24'h000000};
      tbl[3] = '{24'h127000, 1'b1, 24'h000000};
      tbl[4] = '{24'h194530, 1'b0, 24'h194530};
      tbl[5] = '{24'h200000, 1'b0, 24'h200000};
      tbl[6] = '{24'h235959, 1'b0, 24'h235959};
      tbl[7] = '{24'h300000, 1'b1, 24'h000000};
      tbl[8] = '{24'h000060, 1'b1, 24'h000000};
      tbl[9] = '{24'h0A0000, 1'b1, 24'h000000};

      // Reset state.
      step(2);
      chk("rst_time", 32'(dut_bcd()), 32'h0);
      chk("rst_pulse", 32'(sec_pulse), 32'h0);
      chk("rst_err", 32'(load_err), 32'h0);
      reset = 1'b0;

      // First pulse TICKS cycles after release.
      for (int c = 1; c <= 4; c++) begin
         step(1);
         chk("first_pulse", 32'(sec_pulse), 32'(c == 4));
      end
      chk("first_sec", 32'(dut_bcd()), 32'h000001);
      step(8);
      chk("sec_after_12", 32'(dut_bcd()), 32'h000003);

      // Table of loads: valid and rejected times.
      for (int i = 0; i < 10; i++) begin
         load_time(tbl[i].in);
         chk("tbl_time", 32'(dut_bcd()), 32'(tbl[i].exp));
         chk("tbl_err", 32'(load_err), 32'(tbl[i].err));
         step(1);
         chk("tbl_err_clr", 32'(load_err), 32'h0);
      end

      // Midnight rollover.
      load_time(24'h235958);
      step(4);
      chk("roll_59", 32'(dut_bcd()), 32'h235959);
      step(4);
      chk("roll_mid", 32'(dut_bcd()), 32'h000000);

      // Hour carry 09:59:59 -> 10:00:00.
      load_time(24'h095959);
      step(4);
      chk("hour_carry", 32'(dut_bcd()), 32'h100000);

      // isset on the terminal-count cycle drops the tick.
      load_time(24'h120000);
      step(3);
      isset = 1'b1;
      step(1);
      chk("drop_pulse", 32'(sec_pulse), 32'h0);
      chk("drop_time", 32'(dut_bcd()), 32'h120000);
      held = dut_bcd();
      for (int c = 0; c < 20; c++) begin
         step(1);
         chk("hold_time", 32'(dut_bcd()), 32'(held));
         chk("hold_pulse", 32'(sec_pulse), 32'h0);
      end
      isset = 1'b0;
      step(2);
      chk("reload", 32'(dut_bcd()), 32'h120000);
      for (int c = 1; c <= 4; c++) begin
         step(1);
         chk("rerun_pulse", 32'(sec_pulse), 32'(c == 4));
      end

      // Async reset mid-count.
      load_time(24'h123456);
      step(2);
      #2 reset = 1'b1;
      #1;
      chk("async_rst", 32'(dut_bcd()), 32'h0);
      chk("async_pulse", 32'(sec_pulse), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      step(1);

      // isset re-asserted during the LOAD cycle.
      isset = 1'b1;
      drive_set(24'h070809);
      step(2);
      isset = 1'b0;
      step(1);
      isset = 1'b1;
      step(1);
      chk("load_in_load", 32'(dut_bcd()), 32'h070809);
      step(3);
      chk("set_again", 32'(dut_bcd()), 32'h070809);
      isset = 1'b0;
      step(2);
      chk("load_again", 32'(dut_bcd()), 32'h070809);

      // Random stimulus against the model.
      for (int c = 0; c < 600; c++) begin
         step(1);
         if ($urandom_range(0, 19) == 0) begin
            isset = ~isset;
            if (isset) begin
               set_hour1 = 2'($urandom_range(0, 3));
               set_hour2 = 4'($urandom_range(0, 10));
               set_min1 = 4'($urandom_range(0, 6));
               set_min2 = 4'($urandom_range(0, 9));
               set_sec1 = 4'($urandom_range(0, 6));
               set_sec2 = 4'($urandom_range(0, 10));
            end
         end
      end
      isset = 1'b0;
      step(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/clock_counter.md
Name: clock_counter

Overview:
- Runs the time of day once the set FSM has written a time into it.
- Takes the BCD digits hour1..sec2 from the set FSM and loads them when set mode ends.
- Counts seconds in 24-hour format from an internal 1 Hz prescaler.
- Drives the running digits to the display path; sits between the set FSM and the display mux.

Parameters:
- TICKS_PER_SEC, default 100000000: clk cycles per second. Legal range is 2 or more. Benches use 4.
- PRESC_W, default 27: prescaler counter width. Must satisfy 2**PRESC_W >= TICKS_PER_SEC.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- isset  input  1  level; high = set mode active, counting halted
- set_hour1  input  2  hours tens digit from set FSM
- set_hour2  input  4  hours units digit (BCD)
- set_min1  input  4  minutes tens digit
- set_min2  input  4  minutes units digit
- set_sec1  input  4  seconds tens digit
- set_sec2  input  4  seconds units digit
- hour1  output  2  running hours tens
- hour2  output  4  running hours units
- min1  output  4  running minutes tens
- min2  output  4  running minutes units
- sec1  output  4  running seconds tens
- sec2  output  4  running seconds units
- sec_pulse  output  1  one-cycle strobe on every seconds increment
- load_err  output  1  one-cycle strobe when a rejected time was loaded

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, named reset.
- Reset values: all digit outputs 0 (00:00:00), sec_pulse=0, load_err=0, prescaler=0, state=RUN. The clock runs from midnight after reset. Async assertion clears outputs immediately, mid-count or mid-load.

State RUN:
- Prescaler counts 0..TICKS_PER_SEC-1.
- On the cycle the prescaler is at TICKS_PER_SEC-1:
  - prescaler returns to 0;
  - sec_pulse=1 for that one registered cycle;
  - time increments by one second.
- First sec_pulse after reset appears TICKS_PER_SEC cycles after reset release.
- isset sampled 1 -> SETTING. isset has priority over a coincident terminal tick; that tick is dropped and no sec_pulse is issued.

State SETTING:
- Prescaler held at 0; outputs hold their last value; sec_pulse=0.
- isset sampled 0 -> LOAD.

State LOAD (exactly one cycle):
- Validates the set_* digits.
- Valid: outputs take the set_* values at the end of this cycle.
- Invalid: outputs take 00:00:00 and load_err=1 for one cycle.
- Prescaler is cleared; next state is RUN, or SETTING if isset is sampled 1 during LOAD.
- Latency: outputs show the loaded time on the 2nd rising edge after isset is first sampled low.

Validity rule (all conditions must hold):
- set_hour1 <= 2
- set_hour2 <= 9
- if set_hour1 == 2 then set_hour2 <= 3
- set_min1 <= 5, set_min2 <= 9
- set_sec1 <= 5, set_sec2 <= 9

Increment (BCD ripple, all digits updated in the same cycle):
- sec2 9->0 carries to sec1; sec1 5->0 carries to min2.
- min2 9->0 carries to min1; min1 5->0 carries to hour2.
- hour2 9->0 carries to hour1.
- 23:59:59 -> 00:00:00: hour1=2 and hour2=3 with an incoming carry clears both.
- Outputs never hold an invalid time.

Width rules:
- Digit arithmetic is modulo the limits above; never rely on 4-bit natural wrap.
- Prescaler compare is against TICKS_PER_SEC-1 at PRESC_W bits.

Decomposition:
- Package clock_pkg:
  - state enum RUN/SETTING/LOAD;
  - digit limit constants SEC1_MAX=5, DIG_MAX=9, HOUR1_MAX=2, HOUR2_MAX_AT_20=3;
  - a validity function is_valid_time.
- Sub-module tick_gen, parameters TICKS_PER_SEC and PRESC_W:
  - inputs clk, reset, clear (held high in SETTING/LOAD);
  - output tick, a one-cycle strobe at terminal count.
- Top-level holds the FSM, load/validate logic and BCD carry chain.

Test Plan (TICKS_PER_SEC=4):
1. Release reset, isset=0 -> outputs 00:00:00. sec_pulse high on cycle 4; sec2=1 after it; sec2=3 after 12 cycles.
2. Pulse isset with set digits 2,3,5,9,5,8 (23:59:58), then release -> outputs 23:59:58 two edges after release. After 4 cycles 23:59:59; after 8 cycles 00:00:00.
3. Load 09:59:59 -> after one tick outputs 10:00:00 (hour1=1, hour2=0).
4. Load 24:00:00 (hour1=2, hour2=4) -> outputs 00:00:00, load_err=1 for exactly one cycle. Load 12:7x:00 (min1=7) -> same response.
5. Assert isset on the cycle the prescaler is at 3 -> no sec_pulse. Hold isset 20 cycles: outputs frozen, sec_pulse stays 0. Release -> loaded value, then next sec_pulse exactly 4 cycles after RUN re-entry.
6. Assert reset asynchronously mid-count at 12:34:56 -> outputs 00:00:00 before the next clk edge. Re-assert isset during the LOAD cycle -> load still applied, FSM enters SETTING.
